// File: rtl/spi_reg_file.sv
// Command decoder and register file fed by the SPI slave byte receiver.
// A header byte picks write or read and the start address; the bytes after it form a burst.
module spi_reg_file #(
  parameter int          NREGS = 8,
  parameter logic [7:0]  ID    = 8'hA7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SSEL,
  input  logic [7:0]           cmd,
  input  logic                 cmd_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_load,
  output logic [8*NREGS-1:0]   regs_out,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, HDR, WR, RD} state_t;

  localparam logic [6:0] NR = 7'(NREGS);

  state_t                   state, state_nxt;
  logic [6:0]               ptr, ptr_nxt, rd_addr;
  logic [1:0]               ssel_sync;
  logic                     ssel_s, ssel_q, ssel_fall;
  logic                     wr_hit, rd_hit, err_nxt;
  logic [7:0]               rd_val;
  logic [NREGS-1:0][7:0]    regs;

  assign ssel_s    = ssel_sync[1];
  assign ssel_fall = ssel_q & ~ssel_s;
  assign regs_out  = regs;

  // In-range pointers wrap at the top of the bank; out-of-range pointers stick.
  function automatic logic [6:0] adv(input logic [6:0] p);
    if (p < NR) return (p == NR - 7'd1) ? 7'd0 : p + 7'd1;
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_sync <= 2'b11;
      ssel_q    <= 1'b1;
    end else begin
      ssel_sync <= {ssel_sync[0], SSEL};
      ssel_q    <= ssel_s;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rd_addr   = ptr;
    wr_hit    = 1'b0;
    rd_hit    = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: if (ssel_fall) state_nxt = HDR;
      HDR: if (cmd_valid) begin
        if (cmd[7]) begin
          state_nxt = WR;
          ptr_nxt   = cmd[6:0];
        end else begin
          state_nxt = RD;
          rd_hit    = 1'b1;
          rd_addr   = cmd[6:0];
          ptr_nxt   = adv(cmd[6:0]);
        end
      end
      WR: if (cmd_valid) begin
        if (ptr < NR) wr_hit = 1'b1;
        else          err_nxt = 1'b1;
        ptr_nxt = adv(ptr);
      end
      RD: if (cmd_valid) begin
        rd_hit  = 1'b1;
        ptr_nxt = adv(ptr);
      end
    endcase
    // A byte landing on the closing edge is still processed above.
    if (ssel_s) state_nxt = IDLE;
  end

  // Reads see the registered bank, so a write one cycle earlier is visible.
  always_comb begin
    rd_val = (rd_addr == 7'h7F) ? ID : 8'h00;
    for (int k = 0; k < NREGS; k++)
      if (rd_addr == 7'(k)) rd_val = regs[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 7'd0;
      regs      <= '0;
      tx_data   <= 8'h00;
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      tx_load   <= rd_hit;
      wr_strobe <= wr_hit;
      err       <= err_nxt;
      if (wr_hit) wr_addr <= ptr;
      for (int k = 0; k < NREGS; k++)
        if (wr_hit && ptr == 7'(k)) regs[k] <= cmd;
      if (rd_hit)      tx_data <= rd_val;
      else if (ssel_s) tx_data <= 8'h00;
    end
  end
endmodule
